// File: rtl/usb_tx_pkg.sv
// Shared USB line conventions for the transmit and receive paths:
// SYNC pattern, stuff limit, J/K/SE0 encodings and the TX state type.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'h80;
    localparam logic [2:0] STUFF_LIMIT = 3'd6;

    // {d_plus, d_minus}
    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    // NRZI: a 0 toggles J<->K, a 1 holds the line.
    function automatic logic [1:0] nrzi_next(input logic [1:0] line, input logic bit_val);
        if (bit_val) begin
            return line;
        end
        return (line == J) ? K : J;
    endfunction

    function automatic logic [2:0] ones_next(input logic [2:0] ones, input logic bit_val);
        return bit_val ? ones + 3'd1 : 3'd0;
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-time counter: bit_strobe marks the last clk of each bit time,
// pre_strobe the clk before it. Held at zero while disabled.
module tx_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic enable,
    output logic bit_strobe,
    output logic pre_strobe
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_reg <= '0;
        end else if (!enable || cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign bit_strobe = enable && (cnt_reg == LAST);
    assign pre_strobe = enable && (cnt_reg == PRE);

endmodule

// File: rtl/usb_tx.sv
// USB full-speed packet transmitter: SYNC, FIFO payload, EOP, sent LSB
// first with bit stuffing and NRZI onto registered D+/D- lines.
module usb_tx
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic       tx_empty,
    input  logic [7:0] tx_data,
    output logic       tx_ren,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy,
    output logic       tx_done
);
    tx_state_t  state_reg;
    logic [7:0] shift_reg;
    logic [2:0] bit_cnt_reg;
    logic [2:0] ones_cnt_reg;
    logic       eop_cnt_reg;
    logic [1:0] line_reg;
    logic       tx_busy_reg;
    logic       tx_ren_reg;
    logic       tx_done_reg;

    logic bit_strobe;
    logic pre_strobe;
    logic byte_end;

    tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk        (clk),
        .n_rst      (n_rst),
        .enable     (tx_busy_reg),
        .bit_strobe (bit_strobe),
        .pre_strobe (pre_strobe)
    );

    // Last bit of a byte is on the line and no stuff bit is still owed.
    assign byte_end = (state_reg == ST_SYNC || state_reg == ST_DATA) &&
                      (bit_cnt_reg == 3'd7) && (ones_cnt_reg != STUFF_LIMIT);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg    <= ST_IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            ones_cnt_reg <= '0;
            eop_cnt_reg  <= 1'b0;
            line_reg     <= J;
            tx_busy_reg  <= 1'b0;
            tx_ren_reg   <= 1'b0;
            tx_done_reg  <= 1'b0;
        end else begin
            // Pop decision is made one clk early so tx_ren lines up with the strobe.
            tx_ren_reg  <= pre_strobe && byte_end && !tx_empty;
            tx_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (tx_start && !tx_done_reg) begin
                        state_reg    <= ST_SYNC;
                        bit_cnt_reg  <= '0;
                        ones_cnt_reg <= '0;
                    end
                end
                ST_SYNC, ST_DATA: begin
                    if (!tx_busy_reg) begin
                        tx_busy_reg  <= 1'b1;
                        line_reg     <= nrzi_next(line_reg, SYNC_BYTE[0]);
                        ones_cnt_reg <= ones_next(3'd0, SYNC_BYTE[0]);
                        shift_reg    <= {1'b0, SYNC_BYTE[7:1]};
                        bit_cnt_reg  <= '0;
                    end else if (bit_strobe) begin
                        if (ones_cnt_reg == STUFF_LIMIT) begin
                            line_reg     <= nrzi_next(line_reg, 1'b0);
                            ones_cnt_reg <= '0;
                        end else if (bit_cnt_reg != 3'd7) begin
                            line_reg     <= nrzi_next(line_reg, shift_reg[0]);
                            ones_cnt_reg <= ones_next(ones_cnt_reg, shift_reg[0]);
                            shift_reg    <= {1'b0, shift_reg[7:1]};
                            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                        end else if (tx_ren_reg) begin
                            state_reg    <= ST_DATA;
                            line_reg     <= nrzi_next(line_reg, tx_data[0]);
                            ones_cnt_reg <= ones_next(ones_cnt_reg, tx_data[0]);
                            shift_reg    <= {1'b0, tx_data[7:1]};
                            bit_cnt_reg  <= '0;
                        end else begin
                            state_reg   <= ST_EOP_SE0;
                            line_reg    <= SE0;
                            eop_cnt_reg <= 1'b0;
                        end
                    end
                end
                ST_EOP_SE0: begin
                    if (bit_strobe) begin
                        if (eop_cnt_reg) begin
                            state_reg <= ST_EOP_J;
                            line_reg  <= J;
                        end else begin
                            eop_cnt_reg <= 1'b1;
                        end
                    end
                end
                ST_EOP_J: begin
                    if (bit_strobe) begin
                        state_reg    <= ST_IDLE;
                        line_reg     <= J;
                        tx_busy_reg  <= 1'b0;
                        tx_done_reg  <= 1'b1;
                        shift_reg    <= '0;
                        bit_cnt_reg  <= '0;
                        ones_cnt_reg <= '0;
                        eop_cnt_reg  <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign d_plus  = line_reg[1];
    assign d_minus = line_reg[0];
    assign tx_busy = tx_busy_reg;
    assign tx_ren  = tx_ren_reg;
    assign tx_done = tx_done_reg;

endmodule

// File: tb/tb_usb_tx.sv
// Bench for usb_tx: directed packets push expected line symbols, pop cycles
// and lengths into queues; a monitor decodes the bus and compares.
module tb_usb_tx;
    localparam int CPB = 8;
    localparam byte SJ = "J";
    localparam byte SK = "K";
    localparam byte S0 = "0";

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       tx_start = 1'b0;
    logic       tx_empty = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ren;
    logic       d_plus;
    logic       d_minus;
    logic       tx_busy;
    logic       tx_done;

    always #5 clk = ~clk;

    usb_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .tx_start (tx_start),
        .tx_empty (tx_empty),
        .tx_data  (tx_data),
        .tx_ren   (tx_ren),
        .d_plus   (d_plus),
        .d_minus  (d_minus),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    int         n_chk = 0;
    int         n_pass = 0;
    bit         mon_en = 1'b0;
    int         pkt_cnt = 0;
    int         cyc = 0;
    bit         busy_prev = 1'b0;
    logic [7:0] fifo_q[$];
    byte        exp_sym[$];
    int         exp_ren[$];
    int         exp_len[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic byte sym_of(input logic dp, input logic dm);
        case ({dp, dm})
            2'b10:   return SJ;
            2'b01:   return SK;
            2'b00:   return S0;
            default: return "X";
        endcase
    endfunction

    task automatic refresh_fifo();
        tx_empty = (fifo_q.size() == 0);
        tx_data  = tx_empty ? 8'h00 : fifo_q[0];
    endtask

    // First-word-fall-through FIFO model; pops on tx_ren just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            if (tx_ren) begin
                #1;
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                refresh_fifo();
            end
        end
    end

    // Monitor: samples mid-bit, checks pop timing and packet framing.
    initial begin
        byte s;
        forever begin
            @(negedge clk);
            if (!n_rst || !mon_en) begin
                busy_prev = 1'b0;
                cyc = 0;
            end else begin
                if (tx_busy && !busy_prev) begin
                    cyc = 0;
                    pkt_cnt++;
                end
                if (tx_ren) begin
                    if (exp_ren.size() == 0) chk("unexpected_ren", cyc, -1);
                    else chk("ren_cycle", cyc, exp_ren.pop_front());
                end
                if (tx_busy) begin
                    if (cyc % CPB == CPB / 2) begin
                        s = sym_of(d_plus, d_minus);
                        if (exp_sym.size() == 0) chk("extra_bit", int'(s), 0);
                        else chk("line_sym", int'(s), int'(exp_sym.pop_front()));
                    end
                    cyc++;
                end
                if (!tx_busy && busy_prev) begin
                    chk("done_at_end", int'(tx_done), 1);
                    if (exp_len.size() == 0) chk("extra_pkt", cyc, 0);
                    else chk("pkt_cycles", cyc, exp_len.pop_front() * CPB);
                    chk("idle_line_J", int'(sym_of(d_plus, d_minus)), int'(SJ));
                end else if (tx_done) begin
                    chk("spurious_done", int'(tx_done), 0);
                end
                busy_prev = tx_busy;
            end
        end
    end

    task automatic run_pkt(input int nbytes, input logic [7:0] b0, input logic [7:0] b1,
                           input string syms, input int r0, input int r1, input bit hold);
        bit got;
        if (nbytes > 0) fifo_q.push_back(b0);
        if (nbytes > 1) fifo_q.push_back(b1);
        refresh_fifo();
        for (int i = 0; i < syms.len(); i++) exp_sym.push_back(syms[i]);
        exp_len.push_back(syms.len());
        if (nbytes > 0) exp_ren.push_back(r0);
        if (nbytes > 1) exp_ren.push_back(r1);
        @(negedge clk);
        tx_start = 1'b1;
        @(negedge clk);
        if (!hold) tx_start = 1'b0;
        chk("busy_low_after_start_edge", int'(tx_busy), 0);
        @(negedge clk);
        chk("busy_with_first_bit", int'(tx_busy), 1);
        chk("first_bit_K", int'({d_plus, d_minus}), int'(2'b01));
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (tx_done) got = 1'b1;
        end
        chk("done_seen", int'(got), 1);
        if (hold) begin
            @(posedge clk);
            #1 tx_start = 1'b0;
        end
        repeat (30) @(negedge clk);
        $display("packet %0d bytes done, syms=%s", nbytes, syms);
    endtask

    initial begin
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(tx_busy), 0);
        chk("rst_line_J", int'({d_plus, d_minus}), int'(2'b10));
        chk("rst_done", int'(tx_done), 0);
        chk("rst_ren", int'(tx_ren), 0);
        n_rst = 1'b1;

        // Reset asserted in the middle of SYNC.
        fifo_q.push_back(8'h55);
        refresh_fifo();
        @(negedge clk);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_sync_busy", int'(tx_busy), 1);
        n_rst = 1'b0;
        #1;
        chk("async_rst_line_J", int'({d_plus, d_minus}), int'(2'b10));
        chk("async_rst_busy", int'(tx_busy), 0);
        chk("async_rst_ren", int'(tx_ren), 0);
        chk("async_rst_done", int'(tx_done), 0);
        @(negedge clk);
        n_rst = 1'b1;
        fifo_q.delete();
        refresh_fifo();
        repeat (5) @(negedge clk);
        mon_en = 1'b1;

        run_pkt(1, 8'h00, 8'h00, "KJKJKJKKJKJKJKJK00J", 63, 0, 1'b0);
        run_pkt(1, 8'hFF, 8'h00, "KJKJKJKKKKKKKJJJJ00J", 63, 0, 1'b0);
        run_pkt(0, 8'h00, 8'h00, "KJKJKJKK00J", 0, 0, 1'b0);
        run_pkt(2, 8'hA5, 8'h3C, "KJKJKJKKKJJKJJKKJKKKKKJK00J", 63, 127, 1'b0);
        run_pkt(1, 8'hFC, 8'h00, "KJKJKJKKJKKKKKKKJ00J", 63, 0, 1'b0);
        run_pkt(1, 8'h00, 8'h00, "KJKJKJKKJKJKJKJK00J", 63, 0, 1'b1);

        chk("packet_count", pkt_cnt, 6);
        chk("syms_left", exp_sym.size(), 0);
        chk("ren_left", exp_ren.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/usb_tx.md
# usb_tx

USB full-speed packet transmitter for the Lab 6 USB link. It pulls payload bytes from a first-word-fall-through TX FIFO and emits a framed packet on the differential bus: a SYNC byte, the payload bytes, and an EOP. Bits are sent LSB first, with bit stuffing and NRZI encoding. It is the transmit counterpart of the receive control unit and uses the same SYNC and EOP line conventions.

## Interface
- CLKS_PER_BIT, default 8: clk cycles per bus bit time; must be ≥ 2.
- clk  in  1  system clock.
- n_rst  in  1  reset; asynchronous, active-low.
- tx_start  in  1  request to send one packet; sampled only in IDLE.
- tx_empty  in  1  TX FIFO empty flag.
- tx_data  in  8  FIFO head byte; valid whenever tx_empty=0.
- tx_ren  out  1  one-cycle FIFO pop; the byte on tx_data is loaded in the same cycle.
- d_plus  out  1  D+ line.
- d_minus  out  1  D− line.
- tx_busy  out  1  high while a packet is on the bus.
- tx_done  out  1  one-cycle pulse when the packet, including EOP, has completed.

## Operation
- Line states:
  - J: d_plus=1, d_minus=0.
  - K: d_plus=0, d_minus=1.
  - SE0: both lines 0.
- Idle bus is J.
- NRZI encoding: a logical 0 toggles J↔K; a logical 1 holds the current line state.
- Bit stuffing:
  - ones_cnt counts consecutive logical 1s across SYNC, byte boundaries and the payload.
  - When ones_cnt reaches 6, the next bit time carries a stuffed 0 (a toggle). The shifter and bit count hold during that bit time.
  - ones_cnt clears on any 0, including a stuffed 0.
  - A stuff bit due after the final payload bit is sent before EOP.
- State machine states:
  - IDLE: line J.
  - SYNC: shifts out SYNC_BYTE = 8'h80, LSB first, so the line pattern is K J K J K J K K.
  - DATA: shifts out payload bytes.
  - EOP_SE0: two bit times of SE0.
  - EOP_J: one bit time of J.
- Transitions:
  - IDLE → SYNC when tx_start=1.
  - From SYNC or DATA, at the end of the 8th bit of a byte:
    - If a stuff bit is pending, send it first.
    - Then, if tx_empty=0, pulse tx_ren, load tx_data and go to DATA.
    - Otherwise go to EOP_SE0.
  - EOP_SE0 → EOP_J after 2 bit times.
  - EOP_J → IDLE after 1 bit time; tx_done pulses in the first IDLE cycle.
- tx_start is ignored in any state other than IDLE.
- If tx_empty=1 after SYNC, a zero-length packet is sent: SYNC then EOP, with no tx_ren.
- Changes to tx_empty within a bit time are ignored; tx_empty is evaluated only at byte-end boundaries.
- Reset (asynchronous, including mid-packet):
  - state IDLE, line J, tx_busy=0, tx_ren=0, tx_done=0.
  - All counters, the shifter and ones_cnt cleared.
  - No partial EOP is emitted.

## Timing
- Bit timer counts 0..CLKS_PER_BIT−1. Its bit strobe fires at CLKS_PER_BIT−1, and every line change is registered on the cycle after a strobe.
- tx_start is sampled high at rising edge k. The first SYNC bit (K) appears on the lines after edge k+1 and lasts exactly CLKS_PER_BIT cycles.
- tx_busy rises with the first SYNC bit and falls with the return to IDLE. It is low in the tx_done cycle.
- tx_ren is one clk wide and coincides with the strobe ending the last bit, or the pending stuff bit, of the previous byte. There is no idle bit time between bytes.
- Packet length in bit times is 8 + 8·N + stuffed bits + 3. With no stuffing, N=1 and CLKS_PER_BIT=8 gives 152 cycles from the first SYNC bit to IDLE.
- All outputs are registered, with no combinational path from inputs to d_plus or d_minus.

## Structure
- Package usb_tx_pkg holds:
  - the state enum;
  - SYNC_BYTE = 8'h80;
  - STUFF_LIMIT = 6;
  - line-state constants J, K and SE0 as 2-bit {d_plus, d_minus}.
- The SYNC pattern, the stuff limit and the J/K/SE0 encodings are shared with the receive side.
- Sub-module tx_bit_timer: a parameterized CLKS_PER_BIT counter with an enable (tx_busy) and a one-cycle bit_strobe output.
- The top level contains the FSM, the 8-bit shifter, a 3-bit bit counter, a 3-bit ones_cnt and the NRZI output register.

## Test plan
- Reset: assert n_rst=0 mid-SYNC → lines go to J immediately; tx_busy=0, tx_ren=0, tx_done=0; the next tx_start produces a fresh SYNC from its first K.
- Single byte 0x00: lines show K J K J K J K K then J K J K J K J K, then SE0 SE0 J; tx_ren pulses once at the end of SYNC; tx_done pulses 152 cycles after the first K.
- Single byte 0xFF: SYNC's final 1 plus 5 data ones → one stuffed toggle after data bit 4, then 3 more ones; 20 bit times (160 cycles) in total.
- Empty FIFO at start: SYNC then EOP; tx_ren never asserted; 11 bit times (88 cycles).
- Bytes 0xA5 then 0x3C: tx_ren pulses exactly 64 cycles apart; the decoded bits match LSB-first order; no stuff bits.
- tx_start held high throughout a packet: exactly one packet is sent; a second packet starts only if tx_start is high in the IDLE cycle following tx_done.
